// File: rtl/mem_arbiter_2p_pkg.sv
// mem_arbiter_2p_pkg
// Shared definitions for the two-port memory arbiter:
//   state_e            - arbiter FSM states (IDLE, ACCESS, RESP)
//   BASE_ADDR_DEFAULT  - default byte address of RAM word 0
//   NUM_REQ            - number of requesters served by the arbiter
package mem_arbiter_2p_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0000;
  localparam int          NUM_REQ           = 2;

endpackage

// File: rtl/mem_addr_decode.sv
// mem_addr_decode
// Purely combinational byte-address decoder for the shared RAM window.
// Ports:
//   addr       in   byte address to check
//   addr_ok    out  1 when addr is word aligned and inside
//                   [BASE_ADDR, BASE_ADDR + 4*MEMORY_DEPTH)
//   word_index out  (addr - BASE_ADDR) >> 2 when addr_ok, else 0
module mem_addr_decode
  import mem_arbiter_2p_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(BASE_ADDR_DEFAULT)
) (
  input  logic [DATA_WIDTH-1:0] addr,
  output logic                  addr_ok,
  output logic [DATA_WIDTH-1:0] word_index
);

  // One extra bit so the window size and the borrow of the subtraction
  // cannot overflow when the window sits at the top of the address space.
  localparam logic [DATA_WIDTH:0] SPAN = (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  logic [DATA_WIDTH:0] offset;

  assign offset = {1'b0, addr} - {1'b0, BASE_ADDR};

  always_comb begin
    // offset MSB set means the subtraction borrowed, i.e. addr < BASE_ADDR
    addr_ok    = (addr[1:0] == 2'b00) && !offset[DATA_WIDTH] && (offset < SPAN);
    word_index = '0;
    if (addr_ok) begin
      word_index = offset[DATA_WIDTH-1:0] >> 2;
    end
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p
// Round-robin arbiter giving two requesters access to one external
// single-port RAM (combinational read, write on clock edge).
// One transaction takes three cycles: IDLE (sample) -> ACCESS -> RESP.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rN_req/we/addr/wdata       request from requester N (byte address)
//   rN_gnt                     pulse during ACCESS for the winner
//   rN_rvalid/rdata/err        response pulse in RESP; rdata/err hold
//   mem_we/addr/wdata          RAM write enable, word index, write data
//   mem_rdata                  RAM combinational read data
module mem_arbiter_2p
  import mem_arbiter_2p_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(BASE_ADDR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [DATA_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [DATA_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  logic                  last_q, last_d;     // index of the requester granted last
  logic                  sel_q, sel_d;       // index of the current winner
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] rdata_d [NUM_REQ];

  logic [NUM_REQ-1:0]    req;
  logic                  win;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] word_index;

  assign req = {r1_req, r0_req};

  // Decode works on the latched address so it is stable through ACCESS.
  mem_addr_decode #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .BASE_ADDR   (BASE_ADDR)
  ) u_decode (
    .addr      (addr_q),
    .addr_ok   (addr_ok),
    .word_index(word_index)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = '0;
    rvalid_d = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    win      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          // On a tie the requester that was not granted last wins.
          win       = (req == 2'b11) ? ~last_q : req[1];
          sel_d     = win;
          last_d    = win;
          we_d      = win ? r1_we    : r0_we;
          addr_d    = win ? r1_addr  : r0_addr;
          wdata_d   = win ? r1_wdata : r0_wdata;
          gnt_d[win] = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        rvalid_d[sel_q] = 1'b1;
        err_d[sel_q]    = ~addr_ok;
        rdata_d[sel_q]  = (addr_ok && !we_q) ? mem_rdata : '0;
        state_d         = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  // RAM drive is derived from flops only; zero outside ACCESS so an
  // asynchronous reset silences the RAM port at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_we    = addr_ok & we_q;
      mem_addr  = word_index;
      mem_wdata = addr_ok ? wdata_q : '0;
    end
  end

  assign r0_gnt    = gnt_q[0];
  assign r1_gnt    = gnt_q[1];
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_err    = err_q[0];
  assign r1_err    = err_q[1];
  assign r0_rdata  = rdata_q[0];
  assign r1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter_2p.sv
module tb_mem_arbiter_2p;
  import mem_arbiter_2p_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Behavioural stand-in for RAM_32: combinational read, clocked write.
  logic [31:0] ram [32] = '{default: 32'h0};
  assign mem_rdata = ram[mem_addr[4:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter_2p dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic req1(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata;
  endtask

  // r0 write expected to be rejected as an address error
  task automatic bad_write(input string tag, input logic [31:0] addr);
    req0(1'b1, addr, 32'hDEAD_BEEF);
    step();
    r0_req = 1'b0;
    check({tag, "_gnt"}, r0_gnt, 1'b1);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    step();
    check({tag, "_rvalid"}, r0_rvalid, 1'b1);
    check({tag, "_err"}, r0_err, 1'b1);
    check({tag, "_rdata"}, r0_rdata, 32'h0);
    $display("TXN r0 write @%h -> err=%0b rdata=%h", addr, r0_err, r0_rdata);
    step();
  endtask

  initial begin
    reset = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    step();
    check("rst_r0_gnt", r0_gnt, 1'b0);
    check("rst_r0_rvalid", r0_rvalid, 1'b0);
    check("rst_r0_rdata", r0_rdata, 32'h0);
    check("rst_r1_err", r1_err, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    step();

    // r0 write 0x12345678 to word 2
    req0(1'b1, 32'h1001_0008, 32'h1234_5678);
    step();
    r0_req = 1'b0;
    check("w_r0_gnt", r0_gnt, 1'b1);
    check("w_r1_gnt", r1_gnt, 1'b0);
    check("w_mem_we", mem_we, 1'b1);
    check("w_mem_addr", mem_addr, 32'd2);
    check("w_mem_wdata", mem_wdata, 32'h1234_5678);
    step();
    check("w_r0_gnt_off", r0_gnt, 1'b0);
    check("w_r0_rvalid", r0_rvalid, 1'b1);
    check("w_r0_err", r0_err, 1'b0);
    check("w_r1_rvalid", r1_rvalid, 1'b0);
    check("w_mem_we_off", mem_we, 1'b0);
    $display("TXN r0 write @10010008 data=12345678 err=%0b", r0_err);
    step();
    check("w_r0_rvalid_off", r0_rvalid, 1'b0);

    // r1 reads back the same word
    req1(1'b0, 32'h1001_0008, 32'h0);
    step();
    r1_req = 1'b0;
    check("r_r1_gnt", r1_gnt, 1'b1);
    check("r_mem_we", mem_we, 1'b0);
    check("r_mem_addr", mem_addr, 32'd2);
    step();
    check("r_r1_rvalid", r1_rvalid, 1'b1);
    check("r_r1_rdata", r1_rdata, 32'h1234_5678);
    check("r_r1_err", r1_err, 1'b0);
    check("r_r0_rvalid", r0_rvalid, 1'b0);
    $display("TXN r1 read @10010008 -> rdata=%h", r1_rdata);
    step();
    check("r_r1_rdata_hold", r1_rdata, 32'h1234_5678);

    // both requesting from reset: r0, r1, r0, r1 every 3 cycles
    reset = 1'b1;
    req0(1'b0, 32'h1001_0008, 32'h0);
    req1(1'b0, 32'h1001_000C, 32'h0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr%0d_r0_gnt", k), r0_gnt, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("rr%0d_r1_gnt", k), r1_gnt, (k % 2 == 1) ? 1'b1 : 1'b0);
      $display("TXN rr grant %0d r0_gnt=%0b r1_gnt=%0b", k, r0_gnt, r1_gnt);
      if (k == 3) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      step();
      check($sformatf("rr%0d_nogntR", k), r0_gnt | r1_gnt, 1'b0);
      step();
      check($sformatf("rr%0d_nogntI", k), r0_gnt | r1_gnt, 1'b0);
    end
    check("rr_r0_rdata", r0_rdata, 32'h1234_5678);

    // address errors: beyond last word, misaligned, below base
    bad_write("oor", 32'h1001_0080);
    bad_write("mis", 32'h1001_0001);
    bad_write("low", 32'h1000_FFFC);
    check("oor_ram0_untouched", ram[0], 32'h0);

    // last valid word
    req0(1'b1, 32'h1001_007C, 32'hA5A5_0031);
    step();
    r0_req = 1'b0;
    check("top_mem_addr", mem_addr, 32'd31);
    check("top_mem_we", mem_we, 1'b1);
    step();
    check("top_err", r0_err, 1'b0);
    $display("TXN r0 write @1001007C err=%0b", r0_err);
    step();
    check("top_ram31", ram[31], 32'hA5A5_0031);

    // reset asserted during ACCESS aborts the write
    req0(1'b1, 32'h1001_0000, 32'hFFFF_FFFF);
    step();
    check("abort_gnt_pre", r0_gnt, 1'b1);
    check("abort_mem_we_pre", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_gnt", r0_gnt, 1'b0);
    check("abort_mem_we", mem_we, 1'b0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    check("abort_rdata", r0_rdata, 32'h0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    r0_req = 1'b0;
    step();
    check("abort_rvalid", r0_rvalid, 1'b0);
    check("abort_ram0", ram[0], 32'h0);
    $display("TXN r0 write @10010000 aborted by reset");
    reset = 1'b0;
    step();

    // request present only during RESP is ignored
    req1(1'b0, 32'h1001_0008, 32'h0);
    step();
    r1_req = 1'b0;
    step();
    check("resp_state", 32'(dut.state_q), 32'(RESP));
    req0(1'b0, 32'h1001_0008, 32'h0);
    #2;
    r0_req = 1'b0;
    step();
    check("resp_req_nognt0", r0_gnt, 1'b0);
    step();
    check("resp_req_nognt1", r0_gnt, 1'b0);
    check("resp_req_idle", 32'(dut.state_q), 32'(IDLE));
    $display("TXN r0 req during RESP only -> gnt=%0b", r0_gnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
